vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between a video line-prefetch
// reader (fixed-length bursts) and a pixel-sensor writer (single words).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no RAM access; arbitrate between sensor and video requests
// VID   | video burst in progress, one read per cycle, BURST beats
// SEN   | single sensor write cycle, ack pulsed
module vga_fb_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int BURST    = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic              i_clk_pixel,
    input  logic              i_rst_n,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_ack,
    output logic              o_vid_rvalid,
    output logic              o_vid_rlast,
    output logic [DATA_W-1:0] o_vid_rdata,
    input  logic              i_sen_req,
    input  logic [ADDR_W-1:0] i_sen_addr,
    input  logic [DATA_W-1:0] i_sen_wdata,
    output logic              o_sen_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        SEN  = 2'd2
    } state_t;

    localparam int                BEAT_W    = (BURST > 2) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
    localparam logic [7:0]        WAIT_LIM  = 8'(MAX_WAIT);

    state_t            state, state_nx;
    logic [BEAT_W-1:0] beat, beat_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [7:0]        wait_cnt, wait_cnt_nx;
    logic              arb_rdy;

    logic              idle_arb, grant_sen, grant_vid;
    logic              mem_en_nx, mem_we_nx, vid_ack_nx, sen_ack_nx;
    logic              rvalid_nx, rlast_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;

    // Arbitration: a starved sensor beats video, otherwise video has priority.
    // arb_rdy holds off the first grant for one edge after reset release.
    assign idle_arb  = (state == IDLE) && arb_rdy;
    assign grant_sen = idle_arb && i_sen_req && ((wait_cnt >= WAIT_LIM) || !i_vid_req);
    assign grant_vid = idle_arb && i_vid_req && !grant_sen;

    // Read data is passed straight through from the RAM, gated by rvalid.
    assign o_vid_rdata = o_vid_rvalid ? i_mem_rdata : '0;

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nx     = state;
        beat_nx      = beat;
        base_nx      = base;
        mem_en_nx    = 1'b0;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = o_mem_addr;
        mem_wdata_nx = o_mem_wdata;
        vid_ack_nx   = 1'b0;
        sen_ack_nx   = 1'b0;
        rvalid_nx    = (state == VID);
        rlast_nx     = (state == VID) && (beat == LAST_BEAT);
        case (state)
            IDLE: begin
                if (grant_sen) begin
                    state_nx     = SEN;
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = i_sen_addr;
                    mem_wdata_nx = i_sen_wdata;
                    sen_ack_nx   = 1'b1;
                end else if (grant_vid) begin
                    state_nx    = VID;
                    base_nx     = i_vid_addr;
                    beat_nx     = '0;
                    mem_en_nx   = 1'b1;
                    mem_addr_nx = i_vid_addr;
                    vid_ack_nx  = 1'b1;
                end
            end
            VID: begin
                if (beat == LAST_BEAT) begin
                    state_nx = IDLE;
                    beat_nx  = '0;
                end else begin
                    beat_nx     = beat + BEAT_W'(1);
                    mem_en_nx   = 1'b1;
                    mem_addr_nx = base + ADDR_W'(beat_nx);
                end
            end
            SEN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                beat_nx  = '0;
            end
        endcase
    end

    // Sensor starvation counter: counts cycles the sensor waits, saturating.
    always_comb begin
        wait_cnt_nx = wait_cnt;
        if (!i_sen_req || grant_sen || (state == SEN)) begin
            wait_cnt_nx = '0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt_nx = wait_cnt + 8'd1;
        end
    end

    // State register and internal counters.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            base     <= '0;
            wait_cnt <= '0;
            arb_rdy  <= 1'b0;
        end else begin
            state    <= state_nx;
            beat     <= beat_nx;
            base     <= base_nx;
            wait_cnt <= wait_cnt_nx;
            arb_rdy  <= 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vid_ack    <= 1'b0;
            o_vid_rvalid <= 1'b0;
            o_vid_rlast  <= 1'b0;
            o_sen_ack    <= 1'b0;
            o_mem_en     <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
        end else begin
            o_vid_ack    <= vid_ack_nx;
            o_vid_rvalid <= rvalid_nx;
            o_vid_rlast  <= rlast_nx;
            o_sen_ack    <= sen_ack_nx;
            o_mem_en     <= mem_en_nx;
            o_mem_we     <= mem_we_nx;
            o_mem_addr   <= mem_addr_nx;
            o_mem_wdata  <= mem_wdata_nx;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, scoreboard of expected RAM accesses and
// read beats, directed scenarios for priority, starvation, wrap, drop and reset.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk_pixel = 1'b0;
    logic              rst_n;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic              vid_rvalid;
    logic              vid_rlast;
    logic [DATA_W-1:0] vid_rdata;
    logic              sen_req;
    logic [ADDR_W-1:0] sen_addr;
    logic [DATA_W-1:0] sen_wdata;
    logic              sen_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;
    int vid_ack_cnt = 0;
    int sen_ack_cnt = 0;
    bit sb_on = 1'b1;

    logic [26:0] mem_q[$];   // {we, addr, wdata (0 for reads)}
    logic [16:0] rd_q[$];    // {last, data}

    logic [DATA_W-1:0] ram     [1024];
    bit                written [1024];
    logic [DATA_W-1:0] ref_mem [1024];
    bit                ref_wr  [1024];

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(8), .MAX_WAIT(16)
    ) dut (
        .i_clk_pixel (clk_pixel),
        .i_rst_n     (rst_n),
        .i_vid_req   (vid_req),
        .i_vid_addr  (vid_addr),
        .o_vid_ack   (vid_ack),
        .o_vid_rvalid(vid_rvalid),
        .o_vid_rlast (vid_rlast),
        .o_vid_rdata (vid_rdata),
        .i_sen_req   (sen_req),
        .i_sen_addr  (sen_addr),
        .i_sen_wdata (sen_wdata),
        .o_sen_ack   (sen_ack),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return 16'(a) * 16'd37 ^ 16'h1000;
    endfunction

    function automatic logic [DATA_W-1:0] ref_val(input logic [ADDR_W-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    // Single-port RAM model, one cycle read latency.
    always @(posedge clk_pixel) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: every RAM access and read beat must match the queue head.
    always @(negedge clk_pixel) begin
        if (vid_ack) vid_ack_cnt++;
        if (sen_ack) sen_ack_cnt++;
        if (sb_on && rst_n) begin
            if (mem_en) begin
                chk("mem_access_expected", 64'(mem_q.size() != 0), 1);
                if (mem_q.size() != 0)
                    chk("mem_access", {mem_we, mem_addr, mem_we ? mem_wdata : 16'h0},
                        mem_q.pop_front());
            end
            if (vid_rvalid) begin
                chk("rvalid_expected", 64'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0)
                    chk("rdata_rlast", {vid_rlast, vid_rdata}, rd_q.pop_front());
            end
            if (vid_rlast) chk("rlast_has_rvalid", vid_rvalid, 1);
        end
    end

    task automatic push_burst(input logic [ADDR_W-1:0] a);
        for (int k = 0; k < 8; k++) begin
            logic [ADDR_W-1:0] ad;
            ad = a + 10'(k);
            mem_q.push_back({1'b0, ad, 16'h0});
            rd_q.push_back({(k == 7), ref_val(ad)});
        end
    endtask

    task automatic push_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_q.push_back({1'b1, a, d});
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
    endtask

    // Wait for a 1-bit condition selected by sel (0 vid_ack, 1 sen_ack, 2 rlast).
    task automatic wait_for(input int sel, input int limit, output int lat);
        lat = 0;
        do begin
            @(negedge clk_pixel);
            lat++;
        end while (!((sel == 0) ? vid_ack : (sel == 1) ? sen_ack : vid_rlast) && lat < limit);
    endtask

    task automatic vid_burst(input logic [ADDR_W-1:0] a, input int exp_lat);
        int lat;
        push_burst(a);
        vid_req  = 1'b1;
        vid_addr = a;
        wait_for(0, 20, lat);
        chk("vid_ack_latency", lat, exp_lat);
        vid_req = 1'b0;
        wait_for(2, 20, lat);
        chk("vid_rlast_after_ack", lat, 8);
        @(negedge clk_pixel);
    endtask

    task automatic sen_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int lat;
        push_write(a, d);
        sen_req   = 1'b1;
        sen_addr  = a;
        sen_wdata = d;
        wait_for(1, 20, lat);
        chk("sen_ack_latency", lat, 1);
        sen_req = 1'b0;
        @(negedge clk_pixel);
    endtask

    initial begin
        int lat, nv, cyc, cnt, sen_before;
        rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
        sen_req = 1'b0; sen_addr = '0; sen_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_wr[i] = 1'b0;
        repeat (3) @(negedge clk_pixel);
        chk("reset_ctrl", {vid_ack, vid_rvalid, vid_rlast, sen_ack, mem_en, mem_we}, 0);
        chk("reset_bus", {mem_addr, mem_wdata, vid_rdata}, 0);

        // Release with a request already pending: grant lands on the second edge.
        rst_n = 1'b1;
        vid_burst(10'h100, 2);
        vid_burst(10'h3FC, 1);

        // Write, then read it back inside a burst.
        sen_write(10'h200, 16'hBEEF);
        vid_burst(10'h1FE, 1);

        // Simultaneous requests, no starvation: video first, sensor next IDLE.
        push_burst(10'h080);
        push_write(10'h300, 16'h1234);
        vid_req = 1'b1; vid_addr = 10'h080;
        sen_req = 1'b1; sen_addr = 10'h300; sen_wdata = 16'h1234;
        wait_for(0, 20, lat);
        chk("simul_vid_ack_lat", lat, 1);
        vid_req = 1'b0;
        wait_for(1, 20, lat);
        chk("simul_sen_ack_lat", lat, 9);
        sen_req = 1'b0;
        @(negedge clk_pixel);

        // Starvation: both held; sensor wins after the second burst, video follows.
        push_burst(10'h0A0);
        push_burst(10'h0A0);
        push_write(10'h310, 16'h5555);
        push_burst(10'h0A0);
        vid_req = 1'b1; vid_addr = 10'h0A0;
        sen_req = 1'b1; sen_addr = 10'h310; sen_wdata = 16'h5555;
        nv = 0; cyc = 0;
        do begin
            @(negedge clk_pixel);
            cyc++;
            if (vid_ack) nv++;
        end while (!sen_ack && cyc < 100);
        chk("starve_sen_ack_seen", sen_ack, 1);
        chk("starve_sen_ack_cycle", cyc, 19);
        chk("starve_bursts_before_sen", nv, 2);
        sen_req = 1'b0;
        wait_for(0, 20, lat);
        chk("starve_next_vid_lat", lat, 2);
        vid_req = 1'b0;
        wait_for(2, 20, lat);
        chk("starve_last_rlast", lat, 8);
        @(negedge clk_pixel);

        // Sensor request raised and dropped while a burst runs: never granted.
        sen_before = sen_ack_cnt;
        push_burst(10'h0C0);
        vid_req = 1'b1; vid_addr = 10'h0C0;
        wait_for(0, 20, lat);
        chk("drop_vid_ack_lat", lat, 1);
        vid_req = 1'b0;
        sen_req = 1'b1; sen_addr = 10'h3AA; sen_wdata = 16'hDEAD;
        repeat (3) @(negedge clk_pixel);
        sen_req = 1'b0;
        wait_for(2, 20, lat);
        repeat (4) @(negedge clk_pixel);
        chk("drop_no_sen_ack", sen_ack_cnt - sen_before, 0);

        // Reset at beat 3 of a burst.
        sb_on = 1'b0;
        vid_req = 1'b1; vid_addr = 10'h040;
        wait_for(0, 20, lat);
        vid_req = 1'b0;
        repeat (3) @(negedge clk_pixel);
        chk("midburst_addr_beat3", {mem_en, mem_addr}, {1'b1, 10'h043});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {vid_ack, vid_rvalid, vid_rlast, sen_ack, mem_en, mem_we}, 0);
        chk("rst_mid_bus", {mem_addr, mem_wdata, vid_rdata}, 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk_pixel);
            if (vid_rvalid || mem_en) cnt++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk_pixel);
            if (vid_rvalid || mem_en) cnt++;
        end
        chk("no_activity_after_reset", cnt, 0);
        sb_on = 1'b1;
        vid_burst(10'h040, 1);

        repeat (4) @(negedge clk_pixel);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("sen_ack_total", sen_ack_cnt, 3);
        chk("vid_ack_total", vid_ack_cnt, 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
